// File: rtl/eth_tx_preamble_ifg.sv
// Ethernet TX framing stage: prepends preamble/SFD to the CRC-stage byte stream
// through a fixed delay line and enforces a minimum inter-frame gap.
module eth_tx_preamble_ifg #(
    parameter int PREAMBLE_BYTES = 7,
    parameter int IFG_BYTES      = 12
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_dv,
    input  logic [7:0]  i_data_in,
    output logic        o_ready,
    output logic        o_tx_en,
    output logic [7:0]  o_tx_data,
    output logic        o_drop,
    output logic [15:0] o_frame_count
);

    localparam int DEPTH = PREAMBLE_BYTES + 1;
    localparam int PW    = $clog2(PREAMBLE_BYTES + 1);
    localparam int IW    = $clog2(IFG_BYTES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREAMBLE,
        S_DATA,
        S_IFG
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_pre_cnt;
    logic [PW-1:0]   w_pre_nxt;
    logic [IW-1:0]   r_ifg_cnt;
    logic [IW-1:0]   w_ifg_nxt;
    logic [DEPTH-1:0] r_dl_dv;
    logic [7:0]      r_dl_data [DEPTH];
    logic            r_cap_open;
    logic            r_rej;
    logic            r_ready;
    logic            r_tx_en;
    logic [7:0]      r_tx_data;
    logic            r_drop;
    logic [15:0]     r_frame_count;

    logic            w_accept;
    logic            w_cap_dv;
    logic            w_drop;
    logic            w_en_nxt;
    logic [7:0]      w_data_nxt;
    logic            w_cnt_inc;

    // r_ready is low for the first cycle after reset even though the state is IDLE.
    assign w_accept = r_ready & i_dv & ~r_rej;
    assign w_cap_dv = i_dv & (w_accept | r_cap_open);
    assign w_drop   = i_dv & ~w_accept & ~r_cap_open & ~r_rej;

    always_comb begin
        w_state_nxt = r_state;
        w_pre_nxt   = r_pre_cnt;
        w_ifg_nxt   = r_ifg_cnt;
        w_en_nxt    = 1'b0;
        w_data_nxt  = '0;
        w_cnt_inc   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_PREAMBLE;
                    w_pre_nxt   = PW'(1);
                    w_en_nxt    = 1'b1;
                    w_data_nxt  = 8'h55;
                end
            end
            S_PREAMBLE: begin
                w_en_nxt = 1'b1;
                if (r_pre_cnt < PW'(PREAMBLE_BYTES)) begin
                    w_data_nxt = 8'h55;
                    w_pre_nxt  = r_pre_cnt + PW'(1);
                end else begin
                    w_data_nxt  = 8'hD5;
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (r_dl_dv[DEPTH-1]) begin
                    w_en_nxt   = 1'b1;
                    w_data_nxt = r_dl_data[DEPTH-1];
                end else begin
                    w_state_nxt = S_IFG;
                    w_ifg_nxt   = IW'(1);
                    w_cnt_inc   = 1'b1;
                end
            end
            S_IFG: begin
                if (r_ifg_cnt == IW'(IFG_BYTES - 1)) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_ifg_nxt = r_ifg_cnt + IW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_pre_cnt     <= '0;
            r_ifg_cnt     <= '0;
            r_dl_dv       <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) r_dl_data[i] <= '0;
            r_cap_open    <= 1'b0;
            r_rej         <= 1'b0;
            r_ready       <= 1'b0;
            r_tx_en       <= 1'b0;
            r_tx_data     <= '0;
            r_drop        <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pre_cnt    <= w_pre_nxt;
            r_ifg_cnt    <= w_ifg_nxt;
            r_dl_dv      <= {r_dl_dv[DEPTH-2:0], w_cap_dv};
            r_dl_data[0] <= i_data_in;
            for (int unsigned i = 1; i < DEPTH; i++) r_dl_data[i] <= r_dl_data[i-1];
            r_cap_open   <= w_accept | (r_cap_open & i_dv);
            r_rej        <= i_dv & (r_rej | w_drop);
            r_ready      <= (w_state_nxt == S_IDLE);
            r_tx_en      <= w_en_nxt;
            r_tx_data    <= w_data_nxt;
            r_drop       <= w_drop;
            if (w_cnt_inc) r_frame_count <= r_frame_count + 16'd1;
        end
    end

    assign o_ready       = r_ready;
    assign o_tx_en       = r_tx_en;
    assign o_tx_data     = r_tx_data;
    assign o_drop        = r_drop;
    assign o_frame_count = r_frame_count;

endmodule

// File: tb/tb_eth_tx_preamble_ifg.sv
// Directed self-checking bench for eth_tx_preamble_ifg: default build (A) and a
// PREAMBLE_BYTES=2 / IFG_BYTES=3 build (B).
module tb_eth_tx_preamble_ifg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        a_reset = 1'b1, a_dv = 1'b0;
    logic [7:0]  a_data = '0;
    logic        a_ready, a_tx_en, a_drop;
    logic [7:0]  a_tx_data;
    logic [15:0] a_count;

    logic        b_reset = 1'b1, b_dv = 1'b0;
    logic [7:0]  b_data = '0;
    logic        b_ready, b_tx_en, b_drop;
    logic [7:0]  b_tx_data;
    logic [15:0] b_count;

    eth_tx_preamble_ifg u_a (
        .i_clk(clk), .i_reset(a_reset), .i_dv(a_dv), .i_data_in(a_data),
        .o_ready(a_ready), .o_tx_en(a_tx_en), .o_tx_data(a_tx_data),
        .o_drop(a_drop), .o_frame_count(a_count)
    );

    eth_tx_preamble_ifg #(.PREAMBLE_BYTES(2), .IFG_BYTES(3)) u_b (
        .i_clk(clk), .i_reset(b_reset), .i_dv(b_dv), .i_data_in(b_data),
        .o_ready(b_ready), .o_tx_en(b_tx_en), .o_tx_data(b_tx_data),
        .o_drop(b_drop), .o_frame_count(b_count)
    );

    // Output monitors: bytes with their cycle, high-run lengths, preceding low-run lengths.
    logic [7:0] qa_data[$], qb_data[$];
    int qa_cyc[$], qb_cyc[$], runs_a[$], runs_b[$], gaps_a[$], gaps_b[$];
    int hi_a = 0, lo_a = 0, hi_b = 0, lo_b = 0, drops_a = 0, drops_b = 0;
    logic prev_a = 1'b0, prev_b = 1'b0;

    always @(negedge clk) begin
        if (a_tx_en) begin
            qa_data.push_back(a_tx_data);
            qa_cyc.push_back(cyc);
            if (!prev_a) begin gaps_a.push_back(lo_a); hi_a <= 1; end
            else hi_a <= hi_a + 1;
        end else begin
            if (prev_a) begin runs_a.push_back(hi_a); lo_a <= 1; end
            else lo_a <= lo_a + 1;
        end
        prev_a <= a_tx_en;
        if (a_drop) drops_a <= drops_a + 1;
    end

    always @(negedge clk) begin
        if (b_tx_en) begin
            qb_data.push_back(b_tx_data);
            qb_cyc.push_back(cyc);
            if (!prev_b) begin gaps_b.push_back(lo_b); hi_b <= 1; end
            else hi_b <= hi_b + 1;
        end else begin
            if (prev_b) begin runs_b.push_back(hi_b); lo_b <= 1; end
            else lo_b <= lo_b + 1;
        end
        prev_b <= b_tx_en;
        if (b_drop) drops_b <= drops_b + 1;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int p, input int i, input logic [7:0] base);
        if (i < p) return 8'h55;
        if (i == p) return 8'hD5;
        return base + 8'(i - p - 1);
    endfunction

    task automatic send_a(input int n, input logic [7:0] base, output int t0);
        int w = 0;
        while (!a_ready && w < 300) begin @(negedge clk); w++; end
        check("a_ready_wait", a_ready, 1);
        t0 = cyc;
        for (int k = 0; k < n; k++) begin
            a_dv = 1'b1; a_data = base + 8'(k);
            @(negedge clk);
        end
        a_dv = 1'b0; a_data = '0;
    endtask

    task automatic send_b(input int n, input logic [7:0] base, output int t0);
        int w = 0;
        while (!b_ready && w < 300) begin @(negedge clk); w++; end
        check("b_ready_wait", b_ready, 1);
        t0 = cyc;
        for (int k = 0; k < n; k++) begin
            b_dv = 1'b1; b_data = base + 8'(k);
            @(negedge clk);
        end
        b_dv = 1'b0; b_data = '0;
    endtask

    // Byte i of a transmitted frame (preamble included) must appear at cycle t0+1+i.
    task automatic check_frame_a(input string tag, input int idx, input int n,
                                 input logic [7:0] base, input int t0);
        for (int i = 0; i < n + 8; i++) begin
            check($sformatf("%s_byte%0d", tag, i), qa_data[idx+i], exp_byte(7, i, base));
            check($sformatf("%s_cyc%0d", tag, i), qa_cyc[idx+i], t0 + 1 + i);
        end
    endtask

    task automatic check_frame_b(input string tag, input int idx, input int n,
                                 input logic [7:0] base, input int t0);
        for (int i = 0; i < n + 3; i++) begin
            check($sformatf("%s_byte%0d", tag, i), qb_data[idx+i], exp_byte(2, i, base));
            check($sformatf("%s_cyc%0d", tag, i), qb_cyc[idx+i], t0 + 1 + i);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, idx, gidx, ridx, w;

        // Reset values while reset is held.
        repeat (3) @(negedge clk);
        check("rst_tx_en", a_tx_en, 0);
        check("rst_tx_data", a_tx_data, 0);
        check("rst_drop", a_drop, 0);
        check("rst_count", a_count, 0);
        check("rst_ready", a_ready, 0);
        a_reset = 1'b0; b_reset = 1'b0;
        @(negedge clk);
        check("rel_ready", a_ready, 1);
        check("rel_ready_b", b_ready, 1);

        // Single 64-byte frame.
        idx = qa_data.size(); ridx = runs_a.size();
        send_a(64, 8'h00, t0);
        repeat (30) @(negedge clk);
        check("f64_size", qa_data.size() - idx, 72);
        check("f64_run_count", runs_a.size() - ridx, 1);
        check("f64_run_len", runs_a[ridx], 72);
        check_frame_a("f64", idx, 64, 8'h00, t0);
        check("f64_count", a_count, 1);

        // Back-to-back frames with upstream waiting on o_ready.
        idx = qa_data.size(); gidx = gaps_a.size();
        send_a(8, 8'h80, t0);
        send_a(8, 8'h90, t1);
        repeat (30) @(negedge clk);
        check("b2b_size", qa_data.size() - idx, 32);
        check("b2b_gap", gaps_a[gidx+1], 12);
        check_frame_a("b2b1", idx, 8, 8'h80, t0);
        check_frame_a("b2b2", idx + 16, 8, 8'h90, t1);
        check("b2b_count", a_count, 3);

        // Burst during IFG is rejected with a single drop pulse.
        idx = qa_data.size();
        send_a(10, 8'h40, t0);
        repeat (11) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            a_dv = 1'b1; a_data = 8'hEE;
            @(negedge clk);
        end
        a_dv = 1'b0; a_data = '0;
        repeat (40) @(negedge clk);
        check("drop_pulses", drops_a, 1);
        check("drop_size", qa_data.size() - idx, 18);
        check_frame_a("drop_f", idx, 10, 8'h40, t0);
        check("drop_count", a_count, 4);

        // 1-byte frame.
        idx = qa_data.size(); ridx = runs_a.size();
        send_a(1, 8'hA5, t0);
        repeat (30) @(negedge clk);
        check("one_size", qa_data.size() - idx, 9);
        check("one_run", runs_a[ridx], 9);
        check("one_last", qa_data[idx+8], 8'hA5);
        check_frame_a("one", idx, 1, 8'hA5, t0);
        check("one_count", a_count, 5);

        // Reset at cycle 20 of a 64-byte frame.
        idx = qa_data.size();
        w = 0;
        while (!a_ready && w < 300) begin @(negedge clk); w++; end
        check("mid_ready_wait", a_ready, 1);
        for (int k = 0; k < 20; k++) begin
            a_dv = 1'b1; a_data = 8'(k);
            @(negedge clk);
        end
        a_reset = 1'b1; a_dv = 1'b0; a_data = '0;
        @(negedge clk);
        check("mid_tx_en", a_tx_en, 0);
        check("mid_tx_data", a_tx_data, 0);
        check("mid_count", a_count, 0);
        check("mid_ready", a_ready, 0);
        a_reset = 1'b0;
        @(negedge clk);
        check("mid_rel_ready", a_ready, 1);
        check("mid_partial", qa_data.size() - idx, 20);
        idx = qa_data.size();
        send_a(4, 8'hC0, t0);
        repeat (30) @(negedge clk);
        check("post_size", qa_data.size() - idx, 12);
        check_frame_a("post", idx, 4, 8'hC0, t0);
        check("post_count", a_count, 1);
        check("post_drops", drops_a, 1);

        // Small build: two 4-byte frames back-to-back.
        idx = qb_data.size(); gidx = gaps_b.size(); ridx = runs_b.size();
        send_b(4, 8'h10, t0);
        send_b(4, 8'h20, t1);
        repeat (20) @(negedge clk);
        check("sb_size", qb_data.size() - idx, 14);
        check("sb_gap", gaps_b[gidx+1], 3);
        check("sb_run1", runs_b[ridx], 7);
        check("sb_run2", runs_b[ridx+1], 7);
        check_frame_b("sb1", idx, 4, 8'h10, t0);
        check_frame_b("sb2", idx + 7, 4, 8'h20, t1);
        check("sb_count", b_count, 2);
        check("sb_drops", drops_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
